// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants for the hazard/forwarding controller: operand-mux select codes and tag width.
// No logic here; latency and backpressure do not apply.
// Select code 2'b11 is reserved and never driven.
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Chooses the forwarding source for one E-stage operand from the M and W destination tags.
// Latency: purely combinational.
// Backpressure: none; the select follows the shadow tags directly.
module fwd_sel
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] rs_e,
    input  logic [AW-1:0] rd_m,
    input  logic          rw_m,
    input  logic [AW-1:0] rd_w,
    input  logic          rw_w,
    output logic [1:0]    sel
);

    // The younger producer in M shadows any older write to the same register in W.
    always_comb begin
        sel = FWD_RF;
        if (rw_m && (rd_m != '0) && (rd_m == rs_e))
            sel = FWD_MEM;
        else if (rw_w && (rd_w != '0) && (rd_w == rs_e))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: E/M/W tag shadows, operand-mux selects, stall/flush and event counters.
// Latency: selects and controls are combinational; shadows and counters update on the next clk edge.
// Backpressure: mem_busy freezes all shadows and counters and suppresses every flush.
module hazard_fwd_ctrl #(
    parameter int REG_AW = hazard_fwd_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic              mem_read_d,
    input  logic              pc_src_e,
    input  logic              mem_busy,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              stall_e,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              rw_e, ld_e, rw_m, rw_w;
    logic              lu;
    logic              lu_stall;
    logic              br_flush;

    fwd_sel #(.AW(REG_AW)) u_fwd_a (
        .rs_e (rs1_e),
        .rd_m (rd_m),
        .rw_m (rw_m),
        .rd_w (rd_w),
        .rw_w (rw_w),
        .sel  (forward_a_e)
    );

    fwd_sel #(.AW(REG_AW)) u_fwd_b (
        .rs_e (rs2_e),
        .rd_m (rd_m),
        .rw_m (rw_m),
        .rd_w (rd_w),
        .rw_w (rw_w),
        .sel  (forward_b_e)
    );

    assign lu = ld_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A taken branch discards the dependent instruction, so it never needs the load-use stall.
    assign lu_stall = lu && !pc_src_e && !mem_busy;
    assign br_flush = pc_src_e && !mem_busy;

    // Inputs pc_src_e/mem_busy are masked so every control reads 0 while reset is held.
    assign stall_f = !rst && ((lu && !pc_src_e) || mem_busy);
    assign stall_d = stall_f;
    assign flush_d = !rst && br_flush;
    assign flush_e = !rst && (lu || pc_src_e) && !mem_busy;
    assign stall_e = !rst && mem_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e        <= '0;
            rs2_e        <= '0;
            rd_e         <= '0;
            rw_e         <= 1'b0;
            ld_e         <= 1'b0;
            rd_m         <= '0;
            rw_m         <= 1'b0;
            rd_w         <= '0;
            rw_w         <= 1'b0;
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
        end else if (!mem_busy) begin
            rd_w <= rd_m;
            rw_w <= rw_m;
            rd_m <= rd_e;
            rw_m <= rw_e;
            if (flush_e) begin
                rs1_e <= '0;
                rs2_e <= '0;
                rd_e  <= '0;
                rw_e  <= 1'b0;
                ld_e  <= 1'b0;
            end else begin
                rs1_e <= rs1_d;
                rs2_e <= rs2_d;
                rd_e  <= rd_d;
                rw_e  <= reg_write_d;
                ld_e  <= mem_read_d;
            end
            if (lu_stall)
                lu_stall_cnt <= lu_stall_cnt + 1'b1;
            if (br_flush)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: hand-computed expectations checked by immediate assertions.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        reg_write_d, mem_read_d, pc_src_e, mem_busy;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        stall_f, stall_d, flush_d, flush_e, stall_e;
    logic [31:0] lu_stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .reg_write_d  (reg_write_d),
        .mem_read_d   (mem_read_d),
        .pc_src_e     (pc_src_e),
        .mem_busy     (mem_busy),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .stall_e      (stall_e),
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one D-stage instruction plus branch/busy inputs, then let them settle.
    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic pc, input logic busy);
        rs1_d = r1; rs2_d = r2; rd_d = rd;
        reg_write_d = rw; mem_read_d = ld; pc_src_e = pc; mem_busy = busy;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;

        // Build some state so the mid-stream reset has something to clear.
        drive(1, 2, 4, 1, 1, 0, 0); cyc();
        drive(4, 0, 0, 0, 0, 1, 0); cyc();
        chk("pre_rst_flush_cnt", flush_cnt, 1);
        drive(4, 4, 4, 1, 1, 0, 0); cyc();
        drive(4, 4, 9, 1, 0, 1, 1);
        rst = 1'b1;
        #1;
        chk("rst_fwd_a",   {30'd0, forward_a_e}, 0);
        chk("rst_fwd_b",   {30'd0, forward_b_e}, 0);
        chk("rst_ctrl",    {27'd0, stall_f, stall_d, flush_d, flush_e, stall_e}, 0);
        chk("rst_lu_cnt",  lu_stall_cnt, 0);
        chk("rst_fl_cnt",  flush_cnt, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc();

        // add x5, then sub reading x5 in rs1, then a reader of x5 in rs2.
        drive(1, 2, 5, 1, 0, 0, 0);
        chk("add_no_stall", {31'd0, stall_f}, 0);
        cyc();
        drive(5, 6, 8, 1, 0, 0, 0); cyc();
        drive(9, 5, 0, 0, 0, 0, 0);
        chk("sub_fwd_a_mem", {30'd0, forward_a_e}, 2);
        chk("sub_fwd_b_rf",  {30'd0, forward_b_e}, 0);
        cyc();
        drive(0, 0, 7, 1, 0, 0, 0);
        chk("rd_fwd_b_wb", {30'd0, forward_b_e}, 1);
        chk("rd_fwd_a_rf", {30'd0, forward_a_e}, 0);
        cyc();

        // Two writes to x7 then a reader: M must beat W.
        drive(0, 0, 7, 1, 0, 0, 0); cyc();
        drive(7, 0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("dbl_fwd_a_mem", {30'd0, forward_a_e}, 2);
        cyc();

        // x0 is never forwarded and a load to x0 never stalls.
        drive(0, 0, 0, 0, 0, 0, 0); cyc();
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("x0_fwd_a", {30'd0, forward_a_e}, 0);
        chk("x0_fwd_b", {30'd0, forward_b_e}, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("x0_ld_no_stall", {31'd0, stall_f}, 0);
        chk("x0_ld_no_flush", {31'd0, flush_e}, 0);
        cyc();

        // Load x3 then a reader of x3 in rs2.
        drive(1, 0, 3, 1, 1, 0, 0); cyc();
        drive(4, 3, 9, 1, 0, 0, 0);
        chk("lu_stall",   {30'd0, stall_f, stall_d}, 3);
        chk("lu_flush",   {30'd0, flush_d, flush_e}, 1);
        cyc();
        chk("lu_cnt_1",     lu_stall_cnt, 1);
        chk("lu_after_bub", {29'd0, stall_f, stall_d, flush_e}, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_b_wb", {30'd0, forward_b_e}, 1);
        chk("lu_no_stall", {31'd0, stall_f}, 0);
        cyc();

        // Branch taken in the same cycle as a load-use: branch wins.
        drive(1, 0, 3, 1, 1, 0, 0); cyc();
        drive(3, 0, 0, 0, 0, 1, 0);
        chk("br_lu_stall", {30'd0, stall_f, stall_d}, 0);
        chk("br_lu_flush", {30'd0, flush_d, flush_e}, 3);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("br_fl_cnt", flush_cnt, 1);
        chk("br_lu_cnt", lu_stall_cnt, 1);
        chk("br_no_flush_d", {31'd0, flush_d}, 0);
        cyc();

        // mem_busy for three cycles during a pending load-use on x6.
        drive(1, 0, 6, 1, 1, 0, 0); cyc();
        for (int i = 0; i < 3; i++) begin
            drive(6, 0, 0, 0, 0, (i == 1), 1);
            chk("busy_stalls", {29'd0, stall_e, stall_f, stall_d}, 7);
            chk("busy_flush",  {30'd0, flush_d, flush_e}, 0);
            cyc();
            chk("busy_lu_cnt", lu_stall_cnt, 1);
            chk("busy_fl_cnt", flush_cnt, 1);
        end
        drive(6, 0, 0, 0, 0, 0, 0);
        chk("rel_stall",   {29'd0, stall_e, stall_f, stall_d}, 3);
        chk("rel_flush_e", {31'd0, flush_e}, 1);
        cyc();
        chk("rel_lu_cnt", lu_stall_cnt, 2);
        chk("rel_no_stall", {31'd0, stall_f}, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rel_fwd_a_wb", {30'd0, forward_a_e}, 1);
        chk("rel_lu_cnt_once", lu_stall_cnt, 2);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Takes decoded register tags from the D stage and tracks them internally through E, M and W shadow registers.
- Drives the 2-bit select codes for both E-stage forwarding muxes (rs1 and rs2 operands).
- Generates load-use stall, branch flush and memory-freeze controls, plus two hazard event counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of each event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_d  in  REG_AW  source register 1 of the instruction in D.
- rs2_d  in  REG_AW  source register 2 of the instruction in D.
- rd_d  in  REG_AW  destination register of the instruction in D.
- reg_write_d  in  1  instruction in D writes the register file.
- mem_read_d  in  1  instruction in D is a load.
- pc_src_e  in  1  branch/jump taken, resolved in E.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- forward_a_e  out  2  select for the rs1 operand mux in E.
- forward_b_e  out  2  select for the rs2 operand mux in E.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the F/D register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  clear the D/E register.
- stall_e  out  1  hold D/E, E/M and M/W (equals mem_busy).
- lu_stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of branch flush events.

Behaviour:
- Select encoding: 00 = register-file value; 01 = W-stage result; 10 = M-stage ALU result; 11 is never driven.
- Internal state:
  - E shadow: rs1_e, rs2_e, rd_e, rw_e, ld_e.
  - M shadow: rd_m, rw_m.
  - W shadow: rd_w, rw_w.
- Reset (asynchronous, active-high) clears all shadows and both counters to 0. While reset is asserted: forward_a_e = forward_b_e = 00, and all stall and flush outputs are 0.
- Forwarding is combinational from the shadow registers. Rule for rs1 (rs2 is identical):
  - 10 if rw_m and rd_m != 0 and rd_m == rs1_e;
  - else 01 if rw_w and rd_w != 0 and rd_w == rs1_e;
  - else 00.
  - M has priority over W.
  - x0 is never forwarded.
- Load-use hazard: lu = ld_e and rd_e != 0 and (rd_e == rs1_d or rd_e == rs2_d).
- Control outputs:
  - stall_f = stall_d = (lu and not pc_src_e) or mem_busy.
  - flush_d = pc_src_e and not mem_busy.
  - flush_e = (lu or pc_src_e) and not mem_busy.
  - stall_e = mem_busy.
- Shadow update on each rising clk:
  - If mem_busy: all shadows hold.
  - Else:
    - W <= M and M <= E.
    - If flush_e, E <= bubble (all fields 0).
    - Otherwise E <= the D inputs.
- Simultaneous lu and pc_src_e: the branch wins. No stall is issued; D and E are flushed so the PC loads the branch target.
- mem_busy overrides lu and pc_src_e: nothing is flushed and nothing advances. Both hazard conditions are re-evaluated after mem_busy drops.
- Counters:
  - lu_stall_cnt increments in cycles where lu and not pc_src_e and not mem_busy.
  - flush_cnt increments in cycles where pc_src_e and not mem_busy.
  - Both wrap modulo 2^CNT_W.
- Latency: a producer in M is visible to E in the same cycle. A load result reaches E through the W path only after exactly one bubble.
- Same-cycle W-to-D register-file bypass is not handled here; the register file provides it.

Decomposition:
- Shared package holds:
  - Forward-select constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_AW.
- The tag-compare rule is instantiated twice, once per operand, as sub-module fwd_sel (rs_e, rd_m, rw_m, rd_w, rw_w -> 2-bit select).
- Shadow registers and counters stay in the top-level block.

Test Plan:
- Reset and sequential forwarding:
  - Assert rst mid-stream -> all outputs 0 immediately.
  - Then issue add x5 (rd=5, rw=1) followed by sub using rs1=5 -> when sub is in E, forward_a_e = 10.
  - One cycle later, an instruction with rs2=5 sees forward_b_e = 01.
- Double producer: two consecutive writes to x7, then a reader with rs1=7 -> forward_a_e = 10, i.e. the younger M producer beats W.
- x0 is never forwarded: write to x0 (rw=1, rd=0), then a reader of x0 -> forward stays 00; a load to x0 followed by a reader causes no stall.
- Load-use: load rd=3, then D holds rs2=3:
  - That cycle: stall_f = stall_d = flush_e = 1 and lu_stall_cnt = 1.
  - Next cycle: forward_b_e = 01 and no stall.
- Branch vs load-use: pc_src_e = 1 in the same cycle as lu -> stall_f = 0, flush_d = flush_e = 1, flush_cnt +1, lu_stall_cnt unchanged.
- mem_busy: hold mem_busy for 3 cycles during a pending lu -> stall_e = stall_f = stall_d = 1, no flushes, shadows and counters frozen; after release the lu stall occurs once.
